div_signed_seq: RTL and testbench

Sequential signed integer divider, the inverse operation of the team's combinational signed multiplier. It converts the operands to magnitude form, runs an unsigned restoring shift-subtract division one quotient bit per clock, and restores the signs of the quotient and remainder. The block sits beside the multiplier in the synthesis library for circuits that need `/` and `%` at low gate count. The gate count scales linearly in N, not quadratically.

---
 rtl/div_signed_seq_pkg.sv | 21 ++
 rtl/div_signed_seq_if.sv | 24 ++
 rtl/div_signed_seq_sign_mag_conv.sv | 17 +
 rtl/div_signed_seq.sv | 131 +++++++++++++
 tb/tb_div_signed_seq.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/div_signed_seq_pkg.sv
// Shared types and helpers for the sequential signed divider.
package div_signed_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    localparam int DEF_N = 8;
    localparam int CNT_W = $clog2(DEF_N);

    // Two's-complement negate of the low w bits of x; upper bits are cleared.
    function automatic logic [63:0] neg2c(input logic [63:0] x, input int w);
        logic [63:0] mask;
        mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (~x + 64'd1) & mask;
    endfunction

endpackage

// File: rtl/div_signed_seq_if.sv
// Handshake and operand/result bundle for div_signed_seq.
interface div_signed_seq_if #(
    parameter int N = 8,
    parameter int M = N
);
    logic         start;
    logic [N-1:0] A;
    logic [M-1:0] B;
    logic         busy;
    logic         done;
    logic [N-1:0] Q;
    logic [M-1:0] R;
    logic         dbz;

    modport master (
        output start, A, B,
        input  busy, done, Q, R, dbz
    );

    modport slave (
        input  start, A, B,
        output busy, done, Q, R, dbz
    );
endinterface

// File: rtl/div_signed_seq_sign_mag_conv.sv
// Conditional two's-complement negation: y = s ? -x : x (mod 2^W).
module sign_mag_conv
    import div_signed_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic         s,
    output logic [W-1:0] y
);

    // Negate when the sign input is set, pass through otherwise.
    always_comb begin
        y = s ? W'(neg2c(64'(x), W)) : x;
    end

endmodule

// File: rtl/div_signed_seq.sv
// Sequential signed divider: magnitude conversion, restoring shift-subtract
// (one quotient bit per clock), then sign fix-up of quotient and remainder.
module div_signed_seq
    import div_signed_pkg::*;
#(
    parameter int N = 8,
    parameter int M = N
) (
    input  logic            clk,
    input  logic            rst_n,
    div_signed_seq_if.slave bus
);

    localparam int CW = $clog2(N);

    state_t         state, state_nx;
    logic [N-1:0]   dvd;      // dividend bits shifting out, quotient bits shifting in
    logic [M-1:0]   prem;     // partial remainder; always < |B| so M bits suffice
    logic [M-1:0]   mag_b;
    logic [M-1:0]   a_low;
    logic [CW-1:0]  cnt;
    logic           sign_q;
    logic           sign_r;
    logic           dbz_pend;

    logic [N-1:0]   abs_a;
    logic [M-1:0]   abs_b;
    logic [N-1:0]   q_fix;
    logic [M-1:0]   r_fix;
    logic [M:0]     p_sh;
    logic [M:0]     trial;

    sign_mag_conv #(.W(N)) u_abs_a (.x(bus.A),  .s(bus.A[N-1]), .y(abs_a));
    sign_mag_conv #(.W(M)) u_abs_b (.x(bus.B),  .s(bus.B[M-1]), .y(abs_b));
    sign_mag_conv #(.W(N)) u_fix_q (.x(dvd),    .s(sign_q),     .y(q_fix));
    sign_mag_conv #(.W(M)) u_fix_r (.x(prem),   .s(sign_r),     .y(r_fix));

    // Shift {P, dividend} left one place and trial-subtract the divisor magnitude.
    always_comb begin
        p_sh  = {prem, dvd[N-1]};
        trial = p_sh - {1'b0, mag_b};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and status outputs.
    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = (bus.B == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                if (cnt == CW'(N - 1)) begin
                    state_nx = FIX;
                end
            end
            FIX: begin
                bus.busy = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, shift-subtract iteration and result registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvd      <= '0;
            prem     <= '0;
            mag_b    <= '0;
            a_low    <= '0;
            cnt      <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            dbz_pend <= 1'b0;
            bus.Q    <= '0;
            bus.R    <= '0;
            bus.dbz  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        dvd      <= abs_a;
                        mag_b    <= abs_b;
                        a_low    <= bus.A[M-1:0];
                        sign_q   <= bus.A[N-1] ^ bus.B[M-1];
                        sign_r   <= bus.A[N-1];
                        dbz_pend <= (bus.B == '0);
                        prem     <= '0;
                        cnt      <= '0;
                    end
                end
                CALC: begin
                    dvd  <= {dvd[N-2:0], ~trial[M]};
                    prem <= trial[M] ? p_sh[M-1:0] : trial[M-1:0];
                    cnt  <= cnt + CW'(1);
                end
                FIX: begin
                    if (dbz_pend) begin
                        bus.Q   <= '1;
                        bus.R   <= a_low;
                        bus.dbz <= 1'b1;
                    end else begin
                        bus.Q   <= q_fix;
                        bus.R   <= r_fix;
                        bus.dbz <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_signed_seq.sv
// Scoreboard bench for div_signed_seq: driver pushes expected results computed
// with plain signed arithmetic; a negedge monitor pops and compares on done.
module tb_div_signed_seq;

    localparam int N = 8;
    localparam int M = 8;

    typedef struct {
        logic [N-1:0] q;
        logic [M-1:0] r;
        logic         dbz;
        longint       t0;
        int           lat;
    } exp_t;

    logic   clk;
    logic   rst_n;
    longint cyc;
    int     n_vec;
    int     n_bad;
    exp_t   sb[$];

    div_signed_seq_if #(.N(N), .M(M)) bus ();

    div_signed_seq #(.N(N), .M(M)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: truncating signed division and dividend-signed remainder.
    function automatic exp_t model(input logic [N-1:0] a, input logic [M-1:0] b);
        exp_t   e;
        longint ai;
        longint bi;
        longint qi;
        longint ri;
        ai = $signed(a);
        bi = $signed(b);
        if (bi == 0) begin
            e.q   = '1;
            e.r   = a[M-1:0];
            e.dbz = 1'b1;
            e.lat = 2;
        end else begin
            qi    = ai / bi;
            ri    = ai % bi;
            e.q   = qi[N-1:0];
            e.r   = ri[M-1:0];
            e.dbz = 1'b0;
            e.lat = N + 2;
        end
        e.t0 = 0;
        return e;
    endfunction

    task automatic do_op(input logic [N-1:0] a, input logic [M-1:0] b, input bit glitch);
        exp_t e;
        int   busy_n;
        bit   seen;
        busy_n = 0;
        seen   = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        #1;
        e    = model(a, b);
        e.t0 = cyc;
        sb.push_back(e);
        bus.start = 1'b0;
        for (int i = 0; i < N + 10; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_n++;
            if (glitch && i == 2) begin
                bus.start = 1'b1;
                bus.A     = ~a;
                bus.B     = M'(3);
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        chk("done_seen", longint'(seen), 1);
        chk("busy_cycles", busy_n, e.lat - 1);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("Q", bus.Q, e.q);
                chk("R", bus.R, e.r);
                chk("dbz", bus.dbz, e.dbz);
                chk("latency", cyc - e.t0 + 1, e.lat);
                chk("busy_at_done", bus.busy, 0);
            end
        end
    end

    initial begin
        logic [N-1:0] ra;
        logic [M-1:0] rb;
        int           sel;
        cyc       = 0;
        n_vec     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_Q", bus.Q, 0);
        chk("rst_R", bus.R, 0);
        chk("rst_dbz", bus.dbz, 0);

        do_op(N'(100),  M'(7),  1'b0);
        do_op(N'(-100), M'(7),  1'b0);
        do_op(N'(100),  M'(-7), 1'b0);
        do_op(N'(-100), M'(-7), 1'b0);
        do_op(N'(-128), M'(-1), 1'b0);
        do_op(N'(-128), M'(1),  1'b0);
        do_op(N'(5),    M'(0),  1'b0);
        do_op(N'(6),    M'(3),  1'b0);
        do_op(N'(100),  M'(7),  1'b1);
        do_op(N'(-100), M'(-7), 1'b0);

        // Abort an operation mid-CALC with an asynchronous reset.
        @(negedge clk);
        bus.start = 1'b1;
        bus.A     = N'(77);
        bus.B     = M'(5);
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_Q", bus.Q, 0);
        chk("async_rst_R", bus.R, 0);
        chk("async_rst_dbz", bus.dbz, 0);
        chk("async_rst_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 4) @(negedge clk);
        chk("no_done_after_abort", longint'(sb.size()), 0);

        do_op(N'(100), M'(7), 1'b0);

        for (int k = 0; k < 40; k++) begin
            ra  = N'($urandom);
            rb  = M'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0) rb = '0;
            if (sel == 1) rb = '1;
            if (sel == 2) ra = {1'b1, {(N-1){1'b0}}};
            if (sel == 3) rb = {1'b1, {(M-1){1'b0}}};
            do_op(ra, rb, 1'b0);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", longint'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
